// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, in-order imem requests, small head-registered
// FIFO toward the controller, branch redirect with stale-response discard.
//
// state | meaning
// IDLE  | first cycle after reset, no request issued
// RUN   | normal fetch, no stale responses pending
// DRAIN | stale responses still in flight; live fetch continues if room
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, ret_pc, target;
  logic [CW-1:0] outstanding, discard, count;
  logic [CW-1:0] out_after, disc_after, disc_flush, count_kept, count_nxt;
  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic          pop, push, rsp_live, rsp_drop, credit_ok, flight_ok;

  // Handshake, credit and in-flight bookkeeping for this cycle.
  // outstanding counts live requests, discard counts stale ones; stale ones
  // are always older, so a response retires discard first.
  // A same-cycle pop frees a slot, which keeps a 1-cycle memory streaming.
  always_comb begin
    target     = branch_target & ~32'h3;
    pop        = instr_valid & instr_ready & ~branch_en;
    rsp_drop   = imem_rvalid & (discard != '0);
    rsp_live   = imem_rvalid & (discard == '0);
    push       = rsp_live & ~branch_en & ~reset;
    credit_ok  = ({1'b0, count} + {1'b0, outstanding}) < (DEPTH_W + (CW+1)'(pop));
    flight_ok  = ({1'b0, outstanding} + {1'b0, discard}) < DEPTH_W;
    imem_req   = ~reset & (state != IDLE) & ~branch_en & credit_ok & flight_ok;
    imem_addr  = fetch_pc;
    out_after  = outstanding + CW'(imem_req) - CW'(rsp_live);
    disc_after = discard - CW'(rsp_drop);
    disc_flush = disc_after + out_after;
    count_kept = count - CW'(pop);
    count_nxt  = count_kept + CW'(push);
    rd_ptr_nxt = rd_ptr + AW'(pop);
  end

  // Next-state: stay in DRAIN while any stale response remains in flight.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       state_nxt = RUN;
      RUN, DRAIN: begin
        if (branch_en) state_nxt = (disc_flush != '0) ? DRAIN : RUN;
        else           state_nxt = (disc_after != '0) ? DRAIN : RUN;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // State, PCs, counters and the registered FIFO head.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      ret_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= disc_flush;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= '0;
    end else begin
      assert (!(push && !pop && count == DEPTH_C));
      state <= state_nxt;
      if (branch_en) begin
        fetch_pc    <= target;
        ret_pc      <= target;
        outstanding <= '0;
        discard     <= disc_flush;
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        instr_valid <= 1'b0;
        instr       <= NOP_INSTR;
        instr_pc    <= '0;
      end else begin
        if (imem_req) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          ret_pc <= ret_pc + 32'd4;
          wr_ptr <= wr_ptr + AW'(1);
        end
        rd_ptr      <= rd_ptr_nxt;
        outstanding <= out_after;
        discard     <= disc_after;
        count       <= count_nxt;
        if (count_nxt == '0) begin
          instr_valid <= 1'b0;
          instr       <= NOP_INSTR;
          instr_pc    <= '0;
        end else if (count_kept == '0) begin
          // head is the word arriving right now
          instr_valid <= 1'b1;
          instr       <= imem_rdata;
          instr_pc    <= ret_pc;
        end else begin
          instr_valid <= 1'b1;
          instr       <= data_mem[rd_ptr_nxt];
          instr_pc    <= pc_mem[rd_ptr_nxt];
        end
      end
    end
  end

  // FIFO storage; returned word tagged with its PC.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= ret_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with programmable latency,
// program-order delivery model, directed scenarios and randomized traffic.
module tb_instr_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'hE1A0_0000;
  localparam int          LOGN     = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch_en = 1'b0;
  logic [31:0] branch_target = '0;
  logic        instr_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .branch_en(branch_en),
    .branch_target(branch_target), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;
  int deliveries = 0;

  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t memq[$];

  logic        log_req   [LOGN];
  logic [31:0] log_addr  [LOGN];
  logic        log_valid [LOGN];
  logic [31:0] log_pc    [LOGN];
  logic [31:0] log_instr [LOGN];

  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_req = RESET_PC;
  logic        prev_reset = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] hold_pc = '0;
  logic [31:0] hold_instr = '0;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return 32'hE011_2003 ^ (a * 32'h0100_0193);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: memory request log, program-order delivery, hold rule.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      log_req[cyc]   = imem_req;
      log_addr[cyc]  = imem_addr;
      log_valid[cyc] = instr_valid;
      log_pc[cyc]    = instr_pc;
      log_instr[cyc] = instr;
    end
    if (prev_reset) begin
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr, NOP);
      chk("rst_pc", instr_pc, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, RESET_PC);
    end
    if (!instr_valid) begin
      chk("empty_instr", instr, NOP);
      chk("empty_pc", instr_pc, 0);
    end
    if (prev_hold) begin
      chk("hold_valid", instr_valid, 1);
      chk("hold_pc", instr_pc, hold_pc);
      chk("hold_instr", instr, hold_instr);
    end
    if (imem_req) begin
      chk("req_blocked", {reset, branch_en}, 0);
      chk("req_addr", imem_addr, exp_req);
      exp_req = exp_req + 32'd4;
      memq.push_back('{addr: imem_addr, due: cyc + lat});
      chk("inflight_le_depth", (memq.size() <= DEPTH), 1);
    end
    if (!reset && !branch_en && instr_valid && instr_ready) begin
      chk("pop_pc", instr_pc, exp_pc);
      chk("pop_instr", instr, word_at(instr_pc));
      exp_pc = exp_pc + 32'd4;
      deliveries++;
    end
    if (reset) begin
      exp_pc  = RESET_PC;
      exp_req = RESET_PC;
    end else if (branch_en) begin
      exp_pc  = branch_target & ~32'h3;
      exp_req = branch_target & ~32'h3;
    end
    prev_reset = reset;
    prev_hold  = !reset && !branch_en && instr_valid && !instr_ready;
    hold_pc    = instr_pc;
    hold_instr = instr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (memq.size() > 0 && memq[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  task automatic cycle(input logic r, input logic br, input logic rdy, input logic [31:0] tgt);
    tick();
    reset         = r;
    branch_en     = br;
    instr_ready   = rdy;
    branch_target = tgt;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic chk_first_valid(string name, int from, logic [31:0] pc_exp);
    int found = -1;
    for (int c = from + 1; c <= cyc && c < LOGN; c++)
      if (found < 0 && log_valid[c]) found = c;
    if (found < 0) chk({name, "_found"}, 0, 1);
    else begin
      chk({name, "_pc"}, log_pc[found], pc_exp);
      chk({name, "_instr"}, log_instr[found], word_at(pc_exp));
    end
  endtask

  initial begin
    int b;
    int seg_start;
    logic r, br, rdy;

    // Priming latency, streaming, and stall/release.
    lat = 1;
    do_reset(2);
    b = cyc + 1;
    for (int k = 1; k <= 20; k++) cycle(1'b0, 1'b0, (k < 8 || k > 13), 32'h0);
    @(negedge clk);
    #1;
    chk("t1_idle_req", log_req[b], 0);
    chk("t1_first_req", log_req[b+1], 1);
    chk("t1_first_addr", log_addr[b+1], 32'h0);
    chk("t1_valid_c3", log_valid[b+2], 0);
    chk("t1_valid_c4", log_valid[b+3], 1);
    chk("t1_instr_c4", log_instr[b+3], 32'hE011_2003);
    chk("t1_pc_c4", log_pc[b+3], 32'h0);
    for (int k = 4; k <= 7; k++) begin
      chk("t1_stream_valid", log_valid[b+k-1], 1);
      chk("t1_stream_pc", log_pc[b+k-1], 32'(4 * (k - 4)));
    end
    chk("t1_stall_valid", log_valid[b+12], 1);
    chk("t1_stall_pc", log_pc[b+12], 32'h10);
    chk("t1_stall_req", log_req[b+12], 0);
    for (int k = 14; k <= 16; k++) begin
      chk("t1_resume_valid", log_valid[b+k-1], 1);
      chk("t1_resume_pc", log_pc[b+k-1], 32'h10 + 32'(4 * (k - 14)));
    end

    // Latency-3 memory, branch with two requests in flight.
    lat = 3;
    do_reset(4);
    b = cyc + 1;
    for (int k = 1; k <= 20; k++) cycle(1'b0, (k == 4), 1'b1, 32'h40);
    @(negedge clk);
    #1;
    chk("t2_req_a", log_req[b+1], 1);
    chk("t2_req_b", log_req[b+2], 1);
    chk("t2_req_b_addr", log_addr[b+2], 32'h4);
    chk("t2_branch_cycle_req", log_req[b+3], 0);
    chk_first_valid("t2_after_branch", b + 3, 32'h40);

    // Branch coinciding with a pop and a returning word; unaligned target.
    lat = 1;
    do_reset(2);
    b = cyc + 1;
    for (int k = 1; k <= 14; k++) cycle(1'b0, (k == 5), 1'b1, 32'h103);
    @(negedge clk);
    #1;
    chk("t3_pop_valid", log_valid[b+4], 1);
    chk("t3_pop_pc", log_pc[b+4], 32'h4);
    chk("t3_flush_valid", log_valid[b+5], 0);
    chk_first_valid("t3_after_branch", b + 4, 32'h100);

    // Reset with one response still in flight.
    lat = 2;
    do_reset(2);
    b = cyc + 1;
    for (int k = 1; k <= 16; k++) cycle((k == 4), 1'b0, (k > 4), 32'h0);
    @(negedge clk);
    #1;
    chk("t4_req_a_addr", log_addr[b+1], 32'h0);
    chk("t4_req_b", log_req[b+2], 1);
    chk("t4_req_b_addr", log_addr[b+2], 32'h4);
    chk("t4_rst_valid", log_valid[b+4], 0);
    chk("t4_rst_instr", log_instr[b+4], NOP);
    chk("t4_rst_pc", log_pc[b+4], 32'h0);
    chk("t4_rst_req", log_req[b+4], 0);
    chk("t4_rst_addr", log_addr[b+4], RESET_PC);
    chk_first_valid("t4_restart", b + 4, RESET_PC);

    // Randomized traffic, one latency per segment.
    for (int s = 0; s < 8; s++) begin
      lat = $urandom_range(1, 3);
      do_reset(4);
      seg_start = deliveries;
      for (int i = 0; i < 400; i++) begin
        r   = ($urandom_range(0, 199) == 0);
        br  = ($urandom_range(0, 99) < 4);
        rdy = ($urandom_range(0, 99) < 70);
        cycle(r, br, rdy, $urandom);
      end
      @(negedge clk);
      #1;
      chk("rand_progress", (deliveries > seg_start), 1);
    end

    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
